// File: rtl/alu_shift_pkg.sv
// ============================================================================
// Module  : alu_shift_pkg
// Purpose : Shared constants and state type for the ALU multi-bit shift path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_shift_pkg;

    localparam int SHIFT_W     = 32;
    localparam int SHIFT_AMT_W = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } seq_state_t;

endpackage : alu_shift_pkg

`default_nettype wire

// File: rtl/shifter.sv
// ============================================================================
// Module  : shifter
// Purpose : Single-bit logical shift cell; passes the operand through when
//           shift is low.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shifter
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_W
) (
    input  logic [WIDTH-1:0] in,
    input  logic             shiftdir,
    input  logic             shift,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = in;
        if (shift) begin
            if (shiftdir == DIR_LEFT) begin
                out = {in[WIDTH-2:0], 1'b0};
            end else begin
                out = {1'b0, in[WIDTH-1:1]};
            end
        end
    end

endmodule : shifter

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ============================================================================
// Module  : shift_sequencer
// Purpose : Multi-bit shift controller; steps the single-bit shifter cell once
//           per clock. Optional SRA behaviour under macro ARITH_SHIFT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_sequencer
    import alu_shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_W,
    parameter int AMT_W = SHIFT_AMT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_dir,
    input  logic             in_arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic [WIDTH-1:0] r_acc;
    logic [AMT_W-1:0] r_cnt;
    logic             r_dir;
    logic [WIDTH-1:0] w_cell_out;
    logic [WIDTH-1:0] w_acc_step;
    logic             w_accept;

    assign w_accept = in_valid && (r_state == S_IDLE);

    shifter #(
        .WIDTH    (WIDTH)
    ) u_shifter (
        .in       (r_acc),
        .shiftdir (r_dir),
        .shift    (1'b1),
        .out      (w_cell_out)
    );

`ifdef ARITH_SHIFT_EN
    logic r_arith;
    logic r_sign;

    // Re-inject the captured sign bit on every right step for SRA.
    always_comb begin
        w_acc_step = w_cell_out;
        if ((r_dir == DIR_RIGHT) && r_arith) begin
            w_acc_step[WIDTH-1] = r_sign;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_arith <= 1'b0;
            r_sign  <= 1'b0;
        end else if (w_accept) begin
            r_arith <= in_arith;
            r_sign  <= in_data[WIDTH-1];
        end
    end
`else
    logic w_unused_arith;
    assign w_unused_arith = in_arith;
    assign w_acc_step     = w_cell_out;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_next_state = (in_amt != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (r_cnt == AMT_W'(1)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_dir   <= DIR_RIGHT;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_acc <= in_data;
                r_cnt <= in_amt;
                r_dir <= in_dir;
            end else if (r_state == S_SHIFT) begin
                r_acc <= w_acc_step;
                r_cnt <= r_cnt - AMT_W'(1);
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state == S_SHIFT);
    assign out_valid = (r_state == S_DONE);
    assign out_data  = (r_state == S_DONE) ? r_acc : '0;

endmodule : shift_sequencer

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
// ============================================================================
// Module  : tb_shift_sequencer
// Purpose : Self-checking bench for shift_sequencer (vector table, corner
//           sequences, randomized traffic against a reference model).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic        in_dir;
    logic        in_arith;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    shift_sequencer #(
        .WIDTH     (32),
        .AMT_W     (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .in_arith  (in_arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  amt;
        logic        dir;
        logic        arith;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference result from the shift definition, independent of the stepping.
    function automatic logic [31:0] ref_shift(input logic [31:0] d, input int amt,
                                              input logic dir, input logic arith);
        logic signed [31:0] sd;
        sd = d;
        if (dir) return d << amt;
`ifdef ARITH_SHIFT_EN
        if (arith) return sd >>> amt;
`else
        if (arith) return d >> amt;
`endif
        return d >> amt;
    endfunction

    task automatic start_op(input logic [31:0] d, input logic [4:0] a,
                            input logic dr, input logic ar);
        in_data  = d;
        in_amt   = a;
        in_dir   = dr;
        in_arith = ar;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Latency counts the accept edge as 1; bounded so the bench never hangs.
    task automatic wait_done(output int lat);
        logic bad;
        bad = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (!busy || out_data !== 32'h0 || in_ready) bad = 1'b1;
            step();
            lat++;
        end
        check("shift_phase_outputs", {31'b0, bad}, 32'h0);
        check("done_reached", {31'b0, out_valid}, 32'h1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_hs_in_ready", {31'b0, in_ready}, 32'h1);
        check("post_hs_out_valid", {31'b0, out_valid}, 32'h0);
    endtask

    task automatic do_op(input string name, input logic [31:0] d, input logic [4:0] a,
                         input logic dr, input logic ar, input logic [31:0] exp);
        int lat;
        check({name, "_in_ready"}, {31'b0, in_ready}, 32'h1);
        start_op(d, a, dr, ar);
        wait_done(lat);
        check({name, "_latency"}, lat, 32'(a) + 32'd1);
        check({name, "_data"}, out_data, exp);
        handshake();
    endtask

    initial begin
        int lat;
        logic [31:0] held;
        logic [31:0] rd;
        logic [4:0]  ra;
        logic        rdir;
        logic        rar;

        vecs[0] = '{32'h0000_00F0, 5'd4,  1'b1, 1'b0, 32'h0000_0F00};
        vecs[1] = '{32'h8000_0001, 5'd0,  1'b0, 1'b0, 32'h8000_0001};
        vecs[2] = '{32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, 32'h0000_0001};
`ifdef ARITH_SHIFT_EN
        vecs[3] = '{32'hFFFF_FFFF, 5'd31, 1'b0, 1'b1, 32'hFFFF_FFFF};
        vecs[4] = '{32'h8000_0000, 5'd4,  1'b0, 1'b1, 32'hF800_0000};
`else
        vecs[3] = '{32'hFFFF_FFFF, 5'd31, 1'b0, 1'b1, 32'h0000_0001};
        vecs[4] = '{32'h8000_0000, 5'd4,  1'b0, 1'b1, 32'h0800_0000};
`endif
        vecs[5] = '{32'h0000_0001, 5'd31, 1'b1, 1'b1, 32'h8000_0000};
        vecs[6] = '{32'h1234_5678, 5'd8,  1'b1, 1'b0, 32'h3456_7800};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0;
        in_dir = 1'b0; in_arith = 1'b0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("reset_in_ready", {31'b0, in_ready}, 32'h1);
        check("reset_out_valid", {31'b0, out_valid}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_out_data", out_data, 32'h0);

        for (int i = 0; i < 7; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].data, vecs[i].amt,
                  vecs[i].dir, vecs[i].arith, vecs[i].exp);
        end

        // Stall in DONE: result frozen and a new request is ignored.
        start_op(32'hA5A5_0000, 5'd1, 1'b0, 1'b0);
        wait_done(lat);
        held = out_data;
        check("hold_data_initial", held, 32'h52D2_8000);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                in_valid = 1'b1; in_data = 32'hFFFF_0000; in_amt = 5'd2; in_dir = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            check("hold_out_valid", {31'b0, out_valid}, 32'h1);
            check("hold_out_data", out_data, held);
            check("hold_in_ready", {31'b0, in_ready}, 32'h0);
        end
        in_valid = 1'b0;
        handshake();
        step();
        check("hold_no_stale_accept", {30'b0, busy, out_valid}, 32'h0);

        // Reset in the middle of a long shift aborts it.
        start_op(32'hDEAD_BEEF, 5'd20, 1'b1, 1'b0);
        repeat (5) step();
        check("mid_busy", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_in_ready", {31'b0, in_ready}, 32'h1);
        check("abort_out_valid", {31'b0, out_valid}, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_out_data", out_data, 32'h0);
        do_op("after_abort", 32'h1, 5'd3, 1'b1, 1'b0, 32'h8);

        // Back-to-back with in_valid held high throughout.
        in_data = 32'h3; in_amt = 5'd2; in_dir = 1'b1; in_arith = 1'b0; in_valid = 1'b1;
        step();
        in_data = 32'hF000_0000; in_amt = 5'd4; in_dir = 1'b0;
        wait_done(lat);
        check("b2b_first_latency", lat, 32'd3);
        check("b2b_first_data", out_data, 32'hC);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("b2b_idle_in_ready", {31'b0, in_ready}, 32'h1);
        step();
        in_valid = 1'b0;
        check("b2b_second_accepted", {31'b0, busy}, 32'h1);
        wait_done(lat);
        check("b2b_second_latency", lat, 32'd5);
        check("b2b_second_data", out_data, 32'h0F00_0000);
        handshake();

        for (int i = 0; i < 40; i++) begin
            rd   = $urandom;
            ra   = 5'($urandom_range(0, 31));
            rdir = 1'($urandom_range(0, 1));
            rar  = 1'($urandom_range(0, 1));
            do_op($sformatf("rand%0d", i), rd, ra, rdir, rar,
                  ref_shift(rd, int'(ra), rdir, rar));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_shift_sequencer

`default_nettype wire
